// File: rtl/fifo_reader.sv
// fifo_reader: pop-side controller for the capture fifo.
// Strobes pop_clock, samples data after a settle window, streams words out.
module fifo_reader #(
  parameter int FIFO_SIZE     = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_ready,
  input  logic                  fifo_pushed_last,
  input  logic                  fifo_popped_last,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  pop_clock,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           word_count,
  output logic [15:0]           burst_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PULSE,
    S_SETTLE,
    S_OUTPUT
  } state_t;

  localparam logic [3:0]  LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LP_LAST_IDX    = 16'(FIFO_SIZE - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_settle;
  logic                  r_pop;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic [15:0]           r_wcount;
  logic [15:0]           r_bcount;

  logic w_settle_done;
  logic w_handshake;
  logic w_start;
  logic w_pop;
  logic w_capture;
  logic w_word_done;
  logic w_burst_done;
  logic w_busy;

  assign w_settle_done = (r_settle == 4'd0);
  assign w_handshake   = r_valid && out_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (enable && (fifo_pushed_last || flush))
          w_next = S_ARM;
      S_ARM:
        if (fifo_ready) w_next = S_PULSE;
      S_PULSE:
        w_next = S_SETTLE;
      S_SETTLE:
        if (w_settle_done) w_next = S_OUTPUT;
      S_OUTPUT:
        if (w_handshake)
          w_next = r_last ? S_IDLE : S_ARM;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Output decode: strobes that steer the registered datapath
  always_comb begin
    w_start      = (r_state == S_IDLE) && (w_next == S_ARM);
    w_pop        = (w_next == S_PULSE);
    w_capture    = (r_state == S_SETTLE) && w_settle_done;
    w_word_done  = (r_state == S_OUTPUT) && w_handshake;
    w_burst_done = w_word_done && r_last;
    w_busy       = (w_next != S_IDLE);
  end

  // Registered outputs, settle timer and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pop    <= 1'b0;
      r_busy   <= 1'b0;
      r_settle <= 4'd0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_wcount <= 16'd0;
      r_bcount <= 16'd0;
    end else begin
      r_pop  <= w_pop;
      r_busy <= w_busy;
      if (r_state == S_PULSE)
        r_settle <= LP_SETTLE_LOAD;
      else if (r_state == S_SETTLE && !w_settle_done)
        r_settle <= r_settle - 4'd1;
      if (w_start)
        r_wcount <= 16'd0;
      else if (w_word_done)
        r_wcount <= r_wcount + 16'd1;
      if (w_capture) begin
        r_data  <= fifo_data;
        r_last  <= fifo_popped_last ||
                   (r_wcount == LP_LAST_IDX);
        r_valid <= 1'b1;
      end else if (w_word_done) begin
        r_valid <= 1'b0;
      end
      if (w_burst_done)
        r_bcount <= r_bcount + 16'd1;
    end
  end

  assign pop_clock   = r_pop;
  assign out_data    = r_data;
  assign out_valid   = r_valid;
  assign out_last    = r_last;
  assign busy        = r_busy;
  assign word_count  = r_wcount;
  assign burst_count = r_bcount;

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Pop-side controller for the capture `fifo`. It drains buffered pixel words onto a valid/ready stream toward the downstream DMA/packer.
- Generates the FIFO's `pop_clock` strobe from the system clock and samples `out_data` after a settle window.
- Tags the last word of each burst and counts completed bursts.
- A burst starts when the FIFO reports full (`pushed_last`) or when a flush is requested.

Parameters:
- FIFO_SIZE, 8: depth of the attached fifo; maximum words per burst.
- DATA_WIDTH, 32: word width.
- SETTLE_CYCLES, 2: clocks between the pop strobe and data capture; legal range 1..15.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows a new burst to start; sampled only in IDLE.
- flush  in  1  level request to drain a partially filled FIFO; sampled only in IDLE.
- fifo_ready  in  1  FIFO not busy; a strobe is issued only when high.
- fifo_pushed_last  in  1  FIFO full indication.
- fifo_popped_last  in  1  the word just popped was the last stored word.
- fifo_data  in  DATA_WIDTH  FIFO `out_data`.
- pop_clock  out  1  pop strobe to the FIFO; registered; exactly 1 clock high per word.
- out_data  out  DATA_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks the final word of a burst; qualified by out_valid.
- busy  out  1  high in any state other than IDLE.
- word_count  out  16  words delivered in the current burst.
- burst_count  out  16  completed bursts; wraps 0xFFFF->0.

Behaviour:
- Reset values: all outputs 0 (pop_clock, out_data, out_valid, out_last, busy, word_count, burst_count); state = IDLE; settle counter = 0.
- Reset mid-burst: outputs are 0 from the next clock. The partial burst is abandoned and burst_count is not incremented.
- States: IDLE, ARM, PULSE, SETTLE, OUTPUT.
- IDLE:
  - If enable && (fifo_pushed_last || flush): clear word_count, go to ARM.
- ARM:
  - Wait for fifo_ready = 1, then go to PULSE.
  - pop_clock stays 0 while waiting.
- PULSE:
  - pop_clock = 1 for this single clock.
  - Next state is SETTLE; settle counter loads SETTLE_CYCLES-1.
- SETTLE:
  - pop_clock = 0; counter decrements each clock.
  - When counter = 0:
    - Register out_data <= fifo_data.
    - out_last <= fifo_popped_last || (word_count == FIFO_SIZE-1).
    - out_valid <= 1.
    - Go to OUTPUT.
- OUTPUT:
  - out_data and out_last are held stable while out_valid && !out_ready.
  - On handshake (out_valid && out_ready):
    - out_valid <= 0 next clock; word_count increments.
    - If out_last: burst_count increments, go to IDLE.
    - Else: go to ARM.
- Latency and throughput:
  - Trigger sampled at edge E0 -> pop_clock high at cycle E1 (if fifo_ready was high) -> out_valid high at cycle E(2+SETTLE_CYCLES).
  - Steady-state word period with out_ready held high: SETTLE_CYCLES+3 clocks.
- Burst length cap: a burst never exceeds FIFO_SIZE words, even if fifo_popped_last never asserts.
- Simultaneous events:
  - enable and flush are ignored outside IDLE; a started burst always completes.
  - If fifo_pushed_last and flush are both high, a single burst starts.
- Empty drain: a flush with an empty FIFO yields one word with the FIFO's empty value 0. That word has out_last = 1 only if fifo_popped_last = 1; otherwise the burst runs to the FIFO_SIZE cap. Software must not flush an empty FIFO; behaviour is defined, not prevented.
- fifo_ready dropping in SETTLE or OUTPUT has no effect; it is checked only in ARM.
- No combinational path from any input to any output.

Test Plan:
- Full burst: preload 8 words 0x11..0x18, fifo_pushed_last = 1, enable = 1, out_ready = 1, SETTLE_CYCLES = 2.
  -> 8 pop_clock pulses, each 1 clock wide, 5 clocks apart.
  -> out_data sequence 0x11..0x18; out_last only on 0x18.
  -> burst_count 0->1; first out_valid 4 clocks after the trigger edge.
- Flush partial: 3 words 0xA0, 0xA1, 0xA2, flush = 1.
  -> 3 words delivered; out_last on 0xA2 (fifo_popped_last = 1).
  -> word_count = 3 at the return to IDLE.
- Backpressure: out_ready low for 10 clocks on word 2.
  -> out_valid, out_data, out_last stable for those 10 clocks.
  -> no pop_clock pulse until the handshake.
- fifo_ready held low 6 clocks in ARM.
  -> pop_clock stays 0; the pulse occurs 1 clock after fifo_ready rises.
- Reset asserted in SETTLE of word 4.
  -> next clock all outputs 0, busy = 0, burst_count unchanged.
  -> a later trigger restarts cleanly with word_count from 0.
- Cap: fifo_popped_last tied 0, 8 words.
  -> out_last asserted on the 8th word; controller returns to IDLE.
